dmem_lsu: RTL and testbench

- Load/store initiator that drives the data-RAM port from the core's memory stage.
- Accepts one load or store per handshake and decodes RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Generates word address, byte-lane enables and lane-replicated write data, and waits out the RAM's 1-cycle synchronous read.
- Returns sign- or zero-extended load data with a response pulse; flags misaligned or illegal accesses without touching memory.

---
 rtl/lsu_pkg.sv | 78 +++++++
 rtl/dmem_lsu_if.sv | 42 ++++
 rtl/lsu_load_extend.sv | 37 +++
 rtl/dmem_lsu.sv | 154 +++++++++++++++
 tb/tb_dmem_lsu.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the data-memory load/store unit:
//   - RISC-V load/store funct3 width/sign codes
//   - FSM state encoding
//   - byte-lane enable constants
//   - helpers that decode legality, store lane enables and store data
// Optional build macro used by the LSU: LSU_RANGE_CHECK_EN (see dmem_lsu.sv).
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [LANES-1:0] BE_NONE    = 4'b0000;
    localparam logic [LANES-1:0] BE_LO_HALF = 4'b0011;
    localparam logic [LANES-1:0] BE_HI_HALF = 4'b1100;
    localparam logic [LANES-1:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } lsu_state_t;

    // Misaligned access or a funct3 that has no meaning for the direction.
    function automatic logic width_err(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lo);
        logic err;
        if (we) begin
            case (f3)
                F3_B:    err = 1'b0;
                F3_H:    err = lo[0];
                F3_W:    err = |lo;
                default: err = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: err = 1'b0;
                F3_H, F3_HU: err = lo[0];
                F3_W:        err = |lo;
                default:     err = 1'b1;
            endcase
        end
        return err;
    endfunction

    function automatic logic [LANES-1:0] store_lanes(input logic [2:0] f3,
                                                     input logic [1:0] lo);
        logic [LANES-1:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << lo;
            F3_H:    be = lo[1] ? BE_HI_HALF : BE_LO_HALF;
            F3_W:    be = BE_WORD;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

    // Right-aligned store data replicated across every lane it could land in,
    // so the RAM only needs the byte enables to pick the right one.
    function automatic logic [31:0] store_data(input logic [2:0] f3,
                                               input logic [31:0] wdata);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{wdata[7:0]}};
            F3_H:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// -----------------------------------------------------------------------------
// dmem_lsu_if
// Bundles the core-side request/response handshake and the data-RAM port.
//   slave  : the LSU (takes requests, drives responses and the RAM port)
//   master : the environment (core memory stage + RAM)
// Signals: req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata,
//          rsp_valid/rsp_rdata/rsp_err,
//          mem_addr/mem_wr_en/mem_wr_byte_en/mem_wr_data/mem_rd_data.
// -----------------------------------------------------------------------------
interface dmem_lsu_if #(
    parameter int ADDR_W = 10,
    parameter int XLEN   = 32
);
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [2:0]          req_funct3;
    logic [31:0]         req_addr;
    logic [XLEN-1:0]     req_wdata;

    logic                rsp_valid;
    logic [XLEN-1:0]     rsp_rdata;
    logic                rsp_err;

    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_wr_en;
    logic [XLEN/8-1:0]   mem_wr_byte_en;
    logic [XLEN-1:0]     mem_wr_data;
    logic [XLEN-1:0]     mem_rd_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wr_en, mem_wr_byte_en, mem_wr_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wr_en, mem_wr_byte_en, mem_wr_data
    );
endinterface

// File: rtl/lsu_load_extend.sv
// -----------------------------------------------------------------------------
// lsu_load_extend
// Combinational lane select and sign/zero extension of a RAM read word.
//   rd_data [31:0] : raw RAM word
//   addr_lo [1:0]  : byte offset of the load
//   funct3  [2:0]  : load width/sign code
//   data    [31:0] : extended load value
// -----------------------------------------------------------------------------
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rd_data,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rd_data[7:0];
            2'd1:    byte_sel = rd_data[15:8];
            2'd2:    byte_sel = rd_data[23:16];
            default: byte_sel = rd_data[31:24];
        endcase
        half_sel = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rd_data;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Load/store initiator between the core memory stage and a synchronous data
// RAM with 1-cycle read latency. One transaction in flight at a time.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : dmem_lsu_if.slave (request/response handshake + RAM port)
// Timing: error response 1 cycle after accept, store response 2 cycles,
// load response 3 cycles. req_ready is high exactly in IDLE.
// Build option: define LSU_RANGE_CHECK_EN to flag addresses with any bit set
// above the RAM's byte range as errors; otherwise those bits alias away.
// -----------------------------------------------------------------------------
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int XLEN   = 32
) (
    input  logic       clk,
    input  logic       rstn,
    dmem_lsu_if.slave  bus
);
    lsu_state_t        state_q, state_d;

    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [LANES-1:0]  be_q, be_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;

    logic              accept;
    logic              range_err;
    logic              req_err;
    logic [31:0]       load_val;

`ifdef LSU_RANGE_CHECK_EN
    assign range_err = |bus.req_addr[31:ADDR_W+2];
`else
    logic unused_hi_addr;
    assign range_err      = 1'b0;
    assign unused_hi_addr = ^bus.req_addr[31:ADDR_W+2];
`endif

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign req_err = width_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0])
                     || range_err;

    lsu_load_extend u_load_extend (
        .rd_data (bus.mem_rd_data),
        .addr_lo (lo_q),
        .funct3  (f3_q),
        .data    (load_val)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        lo_d        = lo_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        mem_addr_d  = mem_addr_q;
        wr_en_d     = 1'b0;
        be_d        = BE_NONE;
        wr_data_d   = wr_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d = bus.req_we;
                    f3_d = bus.req_funct3;
                    lo_d = bus.req_addr[1:0];
                    if (req_err) begin
                        // Rejected in place: answer next cycle, RAM untouched.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = ACCESS;
                        mem_addr_d = bus.req_addr[ADDR_W+1:2];
                        if (bus.req_we) begin
                            wr_en_d   = 1'b1;
                            be_d      = store_lanes(bus.req_funct3, bus.req_addr[1:0]);
                            wr_data_d = store_data(bus.req_funct3, bus.req_wdata);
                        end
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_val;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (!rstn) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            lo_q        <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            wr_en_q     <= 1'b0;
            be_q        <= BE_NONE;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            lo_q        <= lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_addr_q  <= mem_addr_d;
            wr_en_q     <= wr_en_d;
            be_q        <= be_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wr_en      = wr_en_q;
    assign bus.mem_wr_byte_en = be_q;
    assign bus.mem_wr_data    = wr_data_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Directed bench for dmem_lsu with a behavioural 1024-word synchronous RAM.
// Inputs change and outputs are sampled on the falling clock edge.
// Honours LSU_RANGE_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_fails  = 0;

    logic [31:0] ram [0:(1<<ADDR_W)-1];
    logic [31:0] rd_q;

    dmem_lsu_if #(.ADDR_W(ADDR_W), .XLEN(32)) bus ();

    dmem_lsu #(.ADDR_W(ADDR_W), .XLEN(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: byte-lane writes, registered read of the sampled address.
    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_wr_byte_en[i]) ram[bus.mem_addr][8*i +: 8] <= bus.mem_wr_data[8*i +: 8];
        end
        rd_q <= ram[bus.mem_addr];
    end
    assign bus.mem_rd_data = rd_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fails++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; presents one request for one cycle and
    // returns on the falling edge right after the accepting rising edge.
    task automatic send(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

    // Full load: checks the ACCESS cycle, the idle gap and the response.
    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [9:0] exp_maddr,
                           input logic [31:0] exp_data);
        send(1'b0, f3, addr, 32'h0);
        check({tag, " acc mem_addr"}, 32'(bus.mem_addr), 32'(exp_maddr));
        check({tag, " acc wr_en/be"}, {27'd0, bus.mem_wr_en, bus.mem_wr_byte_en}, 32'd0);
        check({tag, " acc ready"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check({tag, " cap rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, " rdata"}, bus.rsp_rdata, exp_data);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [9:0] exp_maddr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        send(1'b1, f3, addr, wdata);
        check({tag, " acc wr_en"}, 32'(bus.mem_wr_en), 32'd1);
        check({tag, " acc mem_addr"}, 32'(bus.mem_addr), 32'(exp_maddr));
        check({tag, " acc byte_en"}, 32'(bus.mem_wr_byte_en), 32'(exp_be));
        check({tag, " acc wr_data"}, bus.mem_wr_data, exp_wdata);
        check({tag, " acc rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, " wr_en dropped"}, 32'(bus.mem_wr_en), 32'd0);
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, " rsp err/rdata"}, {bus.rsp_err, bus.rsp_rdata[30:0]}, 32'd0);
    endtask

    // Illegal request; returns on the falling edge where the response shows.
    task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
        send(we, f3, addr, 32'hFFFF_FFFF);
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd1);
        check({tag, " rdata"}, bus.rsp_rdata, 32'd0);
        check({tag, " wr_en"}, 32'(bus.mem_wr_en), 32'd0);
        check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'h0;
        ram[0] = 32'h5A5A_0001;
        ram[3] = 32'h1234_0078;
        ram[4] = 32'h8001_7FFF;
        ram[8] = 32'hCAFE_F00D;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        rstn = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset ready", 32'(bus.req_ready), 32'd1);
        check("reset rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata[29:0]}, 32'd0);
        check("reset mem", {bus.mem_wr_en, bus.mem_wr_byte_en, 17'd0, bus.mem_addr}, 32'd0);
        check("reset wdata", bus.mem_wr_data, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("post-reset ready", 32'(bus.req_ready), 32'd1);

        // Word store then load back
        do_store("SW 0x08", 3'b010, 32'h08, 32'hDEAD_BEEF, 10'd2, 4'b1111, 32'hDEAD_BEEF);
        check("SW ram word", ram[2], 32'hDEAD_BEEF);
        do_load("LW 0x08", 3'b010, 32'h08, 10'd2, 32'hDEAD_BEEF);

        // Byte store into lane 1, then signed / unsigned byte loads
        do_store("SB 0x0D", 3'b000, 32'h0D, 32'h0000_00A5, 10'd3, 4'b0010, 32'hA5A5_A5A5);
        check("SB ram word", ram[3], 32'h1234_A578);
        do_load("LB 0x0D", 3'b000, 32'h0D, 10'd3, 32'hFFFF_FFA5);
        do_load("LBU 0x0D", 3'b100, 32'h0D, 10'd3, 32'h0000_00A5);

        // Halfword loads from both halves
        do_load("LH 0x12", 3'b001, 32'h12, 10'd4, 32'hFFFF_8001);
        do_load("LHU 0x12", 3'b101, 32'h12, 10'd4, 32'h0000_8001);
        do_load("LH 0x10", 3'b001, 32'h10, 10'd4, 32'h0000_7FFF);

        // Halfword store into the upper half, back-to-back with its response
        do_store("SH 0x12", 3'b001, 32'h12, 32'hFFFF_1357, 10'd4, 4'b1100, 32'h1357_1357);
        check("SH ram word", ram[4], 32'h1357_7FFF);

        // Errors, each new request accepted while the previous err response shows
        do_err("LW 0x06", 1'b0, 3'b010, 32'h06);
        do_err("SH 0x03", 1'b1, 3'b001, 32'h03);
        do_err("LD f3=011", 1'b0, 3'b011, 32'h00);
        do_err("ST f3=100", 1'b1, 3'b100, 32'h00);
        check("err ram untouched", ram[0], 32'h5A5A_0001);
        @(negedge clk);
        check("err pulse ends", 32'(bus.rsp_valid), 32'd0);

        // Reset during the ACCESS cycle of a store
        send(1'b1, 3'b010, 32'h20, 32'h1111_1111);
        check("rst SW acc wr_en", 32'(bus.mem_wr_en), 32'd1);
        rstn = 1'b0;
        #1;
        check("rst wr_en drop", 32'(bus.mem_wr_en), 32'd0);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst no rsp", 32'(bus.rsp_valid), 32'd0);
        check("rst ram kept", ram[8], 32'hCAFE_F00D);
        check("rst ready after", 32'(bus.req_ready), 32'd1);
        do_load("LW 0x20 after rst", 3'b010, 32'h20, 10'd8, 32'hCAFE_F00D);

        // Address above the RAM's byte range
`ifdef LSU_RANGE_CHECK_EN
        do_err("LW 0x1000 range", 1'b0, 3'b010, 32'h1000);
`else
        do_load("LW 0x1000 alias", 3'b010, 32'h1000, 10'd0, 32'h5A5A_0001);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "timeout");
    end
endmodule
